// File: rtl/md_pad6.sv
// md_pad6: controller-side responder for one Mega Drive I/O port.
// Answers the console's TH-select protocol as a 6-button pad (or a plain
// 3-button pad when six_btn_en=0). All pin levels are active-low; bit 6
// echoes the effective TH level. The board merges pad_data with the
// console drive per bit, so bits the console drives are computed but ignored.
module md_pad6 #(
  parameter int TIMEOUT = 80000,
  parameter int TMR_W   = 17
) (
  input  logic        MCLK,
  input  logic        reset,
  input  logic [6:0]  pa_o,
  input  logic [6:0]  pa_d,
  input  logic [11:0] buttons,
  input  logic        six_btn_en,
  output logic [6:0]  pad_data,
  output logic [2:0]  phase
);

  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  logic             th;
  logic             th_q;
  logic             th_prev;
  logic             fall;
  logic             rise;
  logic [TMR_W-1:0] tmr;
  logic [TMR_W-1:0] tmr_nxt;
  logic [2:0]       phase_nxt;
  logic [6:0]       pad_nxt;
  logic [11:0]      nb;
  logic             unused_ok;

  // An undriven TH line is pulled high on the board.
  assign th   = pa_d[6] ? 1'b1 : pa_o[6];
  assign fall = th_prev & ~th_q;
  assign rise = ~th_prev & th_q;
  assign nb   = ~buttons;

  // Only TH matters to the pad; the other console pins are don't-care here.
  assign unused_ok = &{1'b0, pa_o[5:0], pa_d[5:0]};

  // Phase counter and inactivity timer; an edge beats a simultaneous timeout.
  always_comb begin
    tmr_nxt   = tmr + TMR_W'(1);
    phase_nxt = phase;
    if (fall || rise) begin
      tmr_nxt = '0;
    end else if (tmr == TMR_LAST) begin
      tmr_nxt = '0;
    end
    if (!six_btn_en) begin
      phase_nxt = 3'd0;
    end else if (fall) begin
      phase_nxt = (phase == 3'd4) ? 3'd4 : phase + 3'd1;
    end else if (rise) begin
      phase_nxt = phase;
    end else if (tmr == TMR_LAST) begin
      phase_nxt = 3'd0;
    end
  end

  // Pin pattern selected by the current TH level and the updated phase.
  always_comb begin
    pad_nxt = 7'h7F;
    if (th_q) begin
      if (phase_nxt == 3'd3) begin
        pad_nxt = {1'b1, nb[6], nb[5], nb[11], nb[8], nb[9], nb[10]};
      end else begin
        pad_nxt = {1'b1, nb[6], nb[5], nb[3], nb[2], nb[1], nb[0]};
      end
    end else begin
      case (phase_nxt)
        3'd3:    pad_nxt = {1'b0, nb[7], nb[4], 4'b0000};
        3'd4:    pad_nxt = {1'b0, nb[7], nb[4], 4'b1111};
        default: pad_nxt = {1'b0, nb[7], nb[4], 2'b00, nb[1], nb[0]};
      endcase
    end
  end

  // State registers: TH sampling, edge history, phase, timer, output pins.
  always_ff @(posedge MCLK) begin
    if (reset) begin
      th_q     <= 1'b1;
      th_prev  <= 1'b1;
      phase    <= 3'd0;
      tmr      <= '0;
      pad_data <= 7'h7F;
    end else begin
      th_q     <= th;
      th_prev  <= th_q;
      phase    <= phase_nxt;
      tmr      <= tmr_nxt;
      pad_data <= pad_nxt;
    end
  end

endmodule

// File: tb/tb_md_pad6.sv
// tb_md_pad6: self-checking bench for md_pad6 (short timeout for run time).
module tb_md_pad6;

  localparam int TIMEOUT = 200;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  pa_o;
  logic [6:0]  pa_d;
  logic [11:0] buttons;
  logic        six_btn_en;
  logic [6:0]  pad_data;
  logic [2:0]  phase;

  logic [9:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  md_pad6 #(.TIMEOUT(TIMEOUT), .TMR_W(17)) dut (
    .MCLK       (clk),
    .reset      (reset),
    .pa_o       (pa_o),
    .pa_d       (pa_d),
    .buttons    (buttons),
    .six_btn_en (six_btn_en),
    .pad_data   (pad_data),
    .phase      (phase)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [9:0] got, input logic [9:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got phase=%0d pad_data=%02h, expected phase=%0d pad_data=%02h",
               tag, got[9:7], got[6:0], exp[9:7], exp[6:0]);
    end
  endtask

  task automatic expect_out(input logic [2:0] ph, input logic [6:0] pd);
    exp_q.push_back({ph, pd});
  endtask

  task automatic compare_out(input string tag);
    logic [9:0] e;
    e = exp_q.pop_front();
    check(tag, {phase, pad_data}, e);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [11:0] b;
  logic        th_lv[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  logic [6:0]  pad_tb[8] = '{7'h7F, 7'h33, 7'h7F, 7'h33, 7'h7F, 7'h30, 7'h7B, 7'h3F};
  logic [2:0]  ph_tb[8]  = '{3'd0, 3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd3, 3'd4};

  initial begin
    reset = 1'b1; pa_o = 7'h00; pa_d = 7'h7F; buttons = 12'h000; six_btn_en = 1'b1;
    step(3);
    expect_out(3'd0, 7'h7F); compare_out("reset");
    reset = 1'b0;

    // Random buttons, TH undriven (high), phase 0: one-cycle button latency
    for (int i = 0; i < 8; i++) begin
      b = 12'($urandom_range(0, 4095));
      buttons = b;
      expect_out(3'd0, {1'b1, ~b[6], ~b[5], ~b[3], ~b[2], ~b[1], ~b[0]});
      step(1);
      compare_out($sformatf("btn_rand%0d", i));
    end

    // 3-button mode
    six_btn_en = 1'b0; buttons = 12'h041; pa_d = 7'h3F; pa_o = 7'h40;
    expect_out(3'd0, 7'h5E); step(2); compare_out("3btn_th_hi");
    pa_o = 7'h00; buttons = 12'h090;
    expect_out(3'd0, 7'h03); step(2); compare_out("3btn_th_lo");

    // 6-button sequence
    six_btn_en = 1'b1; buttons = 12'h100;
    for (int i = 0; i < 8; i++) begin
      pa_o[6] = th_lv[i];
      expect_out(ph_tb[i], pad_tb[i]);
      step(20);
      compare_out($sformatf("six_lv%0d", i));
    end

    // Timeout clears phase
    pa_o[6] = 1'b1;
    expect_out(3'd4, 7'h7F); step(TIMEOUT + 1); compare_out("pre_timeout");
    expect_out(3'd0, 7'h7F); step(1); compare_out("timeout");
    pa_o[6] = 1'b0;
    expect_out(3'd1, 7'h33); step(4); compare_out("after_timeout");

    // Edge landing on the timeout cycle
    reset = 1'b1; pa_o = 7'h00; pa_d = 7'h7F; buttons = 12'h000;
    expect_out(3'd0, 7'h7F); step(1); compare_out("reset2");
    reset = 1'b0;
    pa_d[6] = 1'b0; pa_o[6] = 1'b0;
    expect_out(3'd1, 7'h33); step(4); compare_out("t5_fall1");
    pa_o[6] = 1'b1;
    expect_out(3'd1, 7'h7F); step(TIMEOUT); compare_out("t5_hold");
    pa_o[6] = 1'b0;
    expect_out(3'd2, 7'h33); step(2); compare_out("t5_edge_on_timeout");
    expect_out(3'd2, 7'h33); step(TIMEOUT - 1); compare_out("t5_tmr_restart");
    expect_out(3'd0, 7'h33); step(1); compare_out("t5_second_timeout");

    // Undriven TH reads high without advancing the phase; mid-sequence reset
    buttons = 12'h100;
    pa_o[6] = 1'b1;
    expect_out(3'd0, 7'h7F); step(4); compare_out("t6_hi");
    pa_o[6] = 1'b0;
    expect_out(3'd1, 7'h33); step(4); compare_out("t6_lo1");
    pa_d[6] = 1'b1;
    expect_out(3'd1, 7'h7F); step(4); compare_out("th_undriven");
    pa_d[6] = 1'b0;
    expect_out(3'd2, 7'h33); step(4); compare_out("t6_lo2");
    pa_o[6] = 1'b1;
    expect_out(3'd2, 7'h7F); step(4); compare_out("t6_hi2");
    pa_o[6] = 1'b0;
    expect_out(3'd3, 7'h30); step(4); compare_out("t6_id");
    pa_o[6] = 1'b1;
    expect_out(3'd3, 7'h7B); step(4); compare_out("t6_ph3_hi");
    reset = 1'b1;
    expect_out(3'd0, 7'h7F); step(1); compare_out("reset_mid");
    reset = 1'b0;

    // Disabling 6-button mode mid-sequence
    pa_o[6] = 1'b0;
    expect_out(3'd1, 7'h33); step(4); compare_out("t7_lo");
    six_btn_en = 1'b0;
    expect_out(3'd0, 7'h33); step(1); compare_out("six_off");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
